// File: rtl/fp_pkg.sv
// Shared float32 types and FSM state encoding for fixed-to-float stimulus paths.
package fp_pkg;

    localparam int FP_BIAS  = 127;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } float32_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ramp_state_t;

endpackage

// File: rtl/fix2float.sv
// Combinational signed Q(32-FRAC_W).FRAC_W to float32 converter.
// Define FP_RAMP_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fix2float
    import fp_pkg::*;
#(
    parameter int FRAC_W = 16
) (
    input  logic [31:0] i_acc,
    output float32_t    o_float
);

`ifdef FP_RAMP_ROUND_NEAREST_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    logic        w_sign;
    logic [31:0] w_mag;
    logic [4:0]  w_p;
    logic [31:0] w_norm;
    logic [7:0]  w_exp;
    logic        w_round;
    logic [23:0] w_man_sum;

    assign w_sign = i_acc[31];
    // 32'h80000000 negates to itself, which is exactly the unsigned magnitude 2^31
    assign w_mag  = w_sign ? (32'd0 - i_acc) : i_acc;

    // Leading-one detector: highest set bit wins
    always_comb begin
        w_p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            w_p = w_mag[i] ? 5'(i) : w_p;
        end
    end

    assign w_norm    = w_mag << (5'd31 - w_p);
    assign w_exp     = 8'(10'(FP_BIAS) + 10'(w_p) - 10'(FRAC_W));
    assign w_round   = ROUND_EN & w_norm[7] & ((|w_norm[6:0]) | w_norm[8]);
    assign w_man_sum = {1'b0, w_norm[30:8]} + {23'd0, w_round};

    // Pack result; a zero magnitude leaves no leading one in w_norm[31]
    always_comb begin
        o_float = '0;
        if (!w_norm[31]) begin
            o_float = '0;
        end else if (w_man_sum[23]) begin
            o_float.sign = w_sign;
            o_float.exp  = w_exp + 8'd1;
            o_float.man  = 23'd0;
        end else begin
            o_float.sign = w_sign;
            o_float.exp  = w_exp;
            o_float.man  = w_man_sum[22:0];
        end
    end

endmodule

// File: rtl/fp_ramp_gen.sv
// Linear ramp stimulus source x[n] = start + n*step, emitted as float32 with valid/ready.
// Optional macro FP_RAMP_ROUND_NEAREST_EN selects round-to-nearest conversion.
module fp_ramp_gen
    import fp_pkg::*;
#(
    parameter int FRAC_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      start_val,
    input  logic [31:0]      step,
    input  logic [CNT_W-1:0] num_samples,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      x_out,
    output logic             busy,
    output logic             done
);

    ramp_state_t      r_state, w_state;
    logic [31:0]      r_acc, w_acc;
    logic [31:0]      r_step, w_step;
    logic [CNT_W-1:0] r_remaining, w_remaining;
    logic             r_valid, w_valid;
    logic [31:0]      r_x, w_x;
    logic             r_busy, w_busy;
    logic             r_done, w_done;

    logic [31:0]      w_acc_next;
    logic [31:0]      w_conv_in;
    float32_t         w_float;

    assign w_acc_next = r_acc + r_step;
    // One converter serves both the first sample and every subsequent one
    assign w_conv_in  = (r_state == IDLE) ? start_val : w_acc_next;

    fix2float #(.FRAC_W(FRAC_W)) u_fix2float (
        .i_acc  (w_conv_in),
        .o_float(w_float)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= 32'd0;
            r_step      <= 32'd0;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_x         <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_acc       <= w_acc;
            r_step      <= w_step;
            r_remaining <= w_remaining;
            r_valid     <= w_valid;
            r_x         <= w_x;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state     = r_state;
        w_acc       = r_acc;
        w_step      = r_step;
        w_remaining = r_remaining;
        w_valid     = r_valid;
        w_x         = r_x;
        w_busy      = r_busy;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (num_samples != '0)) begin
                    w_state     = RUN;
                    w_acc       = start_val;
                    w_step      = step;
                    w_remaining = num_samples;
                    w_x         = w_float;
                    w_valid     = 1'b1;
                    w_busy      = 1'b1;
                end else if (start) begin
                    w_done = 1'b1;
                end else begin
                    w_state = IDLE;
                end
            end
            RUN: begin
                if (r_valid && out_ready && (r_remaining > CNT_W'(1))) begin
                    w_acc       = w_acc_next;
                    w_x         = w_float;
                    w_remaining = r_remaining - CNT_W'(1);
                end else if (r_valid && out_ready) begin
                    w_state     = IDLE;
                    w_remaining = '0;
                    w_valid     = 1'b0;
                    w_busy      = 1'b0;
                    w_done      = 1'b1;
                end else begin
                    w_state = RUN;
                end
            end
            default: begin
                w_state = IDLE;
                w_valid = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign out_valid = r_valid;
    assign x_out     = r_x;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/fp_ramp_gen.md
Name: fp_ramp_gen

Overview:
Programmable stimulus source that produces a stream of IEEE-754 single-precision samples x[n] = start + n*step, forming a linear ramp. It is the driving end of the float-input waveform interface: its output feeds the x input of the waveform blocks (sawtooth, etc.). The accumulator is signed fixed point, and each sample is converted to float32 before it is output. A valid/ready handshake allows backpressure, so a consumer or capture buffer can stall the stream.

Parameters:
FRAC_W, 16, fractional bits of the signed 32-bit fixed-point accumulator (Q(32-FRAC_W).FRAC_W)
CNT_W, 16, width of the sample-count register

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse that launches a ramp; sampled only in IDLE
start_val  in  32  signed fixed-point first sample
step  in  32  signed fixed-point increment per sample
num_samples  in  CNT_W  number of samples to emit
out_valid  out  1  x_out holds a valid sample
out_ready  in  1  consumer accepts the sample this cycle
x_out  out  32  float32 sample {sign, exp[7:0], man[22:0]}
busy  out  1  high in RUN
done  out  1  single-cycle pulse after the last sample is accepted, or after a zero-length start

Behaviour:
- Reset: state=IDLE, acc=0, remaining=0, out_valid=0, x_out=32'h0, busy=0, done=0.
- start_val, step and num_samples are captured only on an accepted start and are ignored otherwise.
- IDLE, start=1, num_samples!=0:
  - next cycle: acc=start_val, remaining=num_samples, x_out=float(start_val), out_valid=1, busy=1, state=RUN.
  - latency is 1 clock from start to the first valid sample.
- IDLE, start=1, num_samples==0: next cycle done=1 for one cycle; state stays IDLE; out_valid stays 0.
- RUN, handshake (out_valid && out_ready):
  - if remaining>1: acc=acc+step, x_out=float(acc+step), remaining-=1, out_valid stays 1.
  - this sustains 1 sample per clock when out_ready is held high.
  - if remaining==1: out_valid=0, busy=0, done=1 for one cycle, state=IDLE.
- RUN, out_valid && !out_ready: x_out, acc and remaining hold. x_out must not change while out_valid=1 and no handshake has occurred.
- start asserted in RUN, including in the same cycle as the final handshake, is ignored.
- Accumulator addition is modulo 2^32 two's complement. It wraps with no saturation and no flag.
- Reset asserted mid-ramp aborts immediately to reset values; no done pulse.
- float() conversion, combinational then registered into x_out:
  - acc==0 gives 32'h00000000; negative zero is never produced.
  - sign=acc[31]; mag=|acc| as a 32-bit unsigned value, so 32'h80000000 gives magnitude 2^31.
  - p = index of the leading one in mag; exp = 127 + p - FRAC_W.
  - man = the bits of mag below p, left-aligned into 23 bits.
  - when p>23, the bits below p-23 are discarded (round toward zero).
  - all results are normal numbers for FRAC_W<=16, so no denormal/inf/NaN handling is required.

Optional Feature:
- Macro FP_RAMP_ROUND_NEAREST_EN.
- Defined: the p>23 case rounds to nearest, ties-to-even, using the guard bit and the OR of the lower bits (sticky).
  - a mantissa carry-out increments exp and clears man.
- Undefined: truncation as described above.
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package fp_pkg:
  - float32_t packed struct {sign, exp[7:0], man[22:0]}
  - localparams FP_BIAS=127, FP_EXP_W=8, FP_MAN_W=23
  - enum ramp_state_t {IDLE, RUN}
- One combinational sub-module fix2float (acc, FRAC_W) -> float32_t.
  - contains the leading-one detector, normalize shift and optional rounding.
  - reusable by other fixed-to-float paths.

Test Plan:
- Basic ramp: start_val=32'hFFFB0000 (-5.0), step=32'h0000028F, num_samples=1000, out_ready=1 -> first x_out=32'hC0A00000 one cycle after start; 1000 consecutive valid samples; done pulses once, in the cycle after the final handshake.
- Exact conversions, num_samples=1:
  - 32'h00010000 -> 32'h3F800000
  - 32'h00008000 -> 32'h3F000000
  - 32'h00000001 -> 32'h37800000
  - 32'h7FFF0000 -> 32'h46FFFE00
  - 0 -> 32'h00000000
- Wrap-around: start_val=32'h7FFF0000, step=32'h00010000, num_samples=2 -> samples 32'h46FFFE00 then 32'hC7000000 (-32768.0).
- Rounding: start_val=32'h7FFFFFFF -> 32'h46FFFFFF without the macro; 32'h47000000 with FP_RAMP_ROUND_NEAREST_EN.
- Backpressure and restart:
  - out_ready toggled randomly -> x_out stable while stalled; no sample lost or duplicated.
  - start pulsed mid-ramp -> ignored.
  - num_samples=0 -> done 1 cycle later with out_valid=0.
- Async reset mid-ramp (between clock edges) -> out_valid, busy and x_out go to 0 immediately; no done pulse; a new start is then accepted normally.
